// File: rtl/eco_pkg.sv
// Shared types and sizes for the ECO equivalence sweeper.
package eco_pkg;

    localparam int VEC_W   = 8;
    localparam int Y_W     = 4;
    localparam int NUM_VEC = 256;
    localparam int CNT_W   = 4;
    localparam int MC_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/eco_equiv_sweeper.sv
// Exhaustive sweep of all {a,b} vectors: drives both the patched netlist and
// the golden model, compares their outputs and gathers mismatch statistics.
module eco_equiv_sweeper
    import eco_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        dut_a,
    output logic [3:0]        dut_b,
    input  logic [Y_W-1:0]    dut_y,
    input  logic [Y_W-1:0]    ref_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MC_W-1:0]   mismatch_count,
    output logic [VEC_W-1:0]  first_fail_vec,
    output logic [Y_W-1:0]    first_fail_diff,
    output logic [Y_W-1:0]    fail_bit_mask
);

    // Reload value: the counter walks LOAD..0, giving SETTLE cycles in SETTLE.
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   vec;
    logic [CNT_W-1:0]   settle_cnt;
    logic [Y_W-1:0]     diff;
    logic               miss;

    assign dut_a = vec[7:4];
    assign dut_b = vec[3:0];
    assign diff  = dut_y ^ ref_y;
    assign miss  = |diff;
    assign busy  = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done  = (state == ST_DONE);

    // Next-state decode; abort wins over settle expiry and over the compare.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (settle_cnt == '0) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (vec == LAST_VEC)  state_nxt = ST_DONE;
                else                       state_nxt = ST_SETTLE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Vector/settle counters and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec             <= '0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            mismatch_count  <= '0;
            first_fail_vec  <= '0;
            first_fail_diff <= '0;
            fail_bit_mask   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec             <= '0;
                        settle_cnt      <= SETTLE_LOAD;
                        pass            <= 1'b0;
                        mismatch_count  <= '0;
                        first_fail_vec  <= '0;
                        first_fail_diff <= '0;
                        fail_bit_mask   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (abort)                  pass       <= 1'b0;
                    else if (settle_cnt != '0)  settle_cnt <= settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (abort) begin
                        // Partial counts are kept; this cycle's compare is dropped.
                        pass <= 1'b0;
                    end else begin
                        if (miss) begin
                            mismatch_count <= mismatch_count + 1'b1;
                            fail_bit_mask  <= fail_bit_mask | diff;
                            if (mismatch_count == '0) begin
                                first_fail_vec  <= vec;
                                first_fail_diff <= diff;
                            end
                        end
                        if (vec != LAST_VEC) begin
                            vec        <= vec + 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    pass <= (mismatch_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
